// File: rtl/mag_power_ctrl.sv
// Magnetron controller: cook FSM (IDLE/COOK/PAUSE/DONE) with duty-cycle power levels.
// The door interlock gates mag_on combinationally. Every other output is registered.
module mag_power_ctrl #(
    parameter int LEVELS = 4,
    parameter int PERIOD = 16,
    parameter int LW     = 2
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          startn,
    input  logic          stopn,
    input  logic          clearn,
    input  logic          door_closed,
    input  logic          timer_done,
    input  logic [LW-1:0] power_sel,
    output logic          mag_on,
    output logic [1:0]    state_o,
    output logic [LW-1:0] level_o,
    output logic          done_pulse
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COOK  = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam int PW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int CW   = PW + 1;
    localparam int STEP = PERIOD / LEVELS;
    localparam logic [PW-1:0] PHASE_LAST = PW'(PERIOD - 1);
    localparam logic [LW-1:0] LEVEL_MAX  = LW'(LEVELS - 1);

    state_t        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [LW-1:0] level_q, level_d;
    logic          done_pulse_q, done_pulse_d;
    logic          start_q, stop_q, clear_q;

    logic          start_ev, stop_ev, clear_ev;
    logic [LW-1:0] level_sat;
    logic [CW-1:0] on_cnt;

    // NOTE: every signal gets a default at the top of the block, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        start_ev  = start_q & ~startn;
        stop_ev   = stop_q  & ~stopn;
        clear_ev  = clear_q & ~clearn;
        level_sat = (power_sel > LEVEL_MAX) ? LEVEL_MAX : power_sel;

        state_d = state_q;
        if (clear_ev) begin
            state_d = IDLE;
        end else if (timer_done && (state_q == COOK || state_q == PAUSE)) begin
            state_d = DONE;
        end else if (state_q == COOK && (!door_closed || stop_ev)) begin
            state_d = PAUSE;
        end else if (start_ev && door_closed && !timer_done &&
                     (state_q == IDLE || state_q == PAUSE)) begin
            state_d = COOK;
        end

        // Power_sel is sampled only on COOK entry or on a phase wrap, so a duty window is never split between two levels.
        phase_d = phase_q;
        level_d = level_q;
        if (state_d == IDLE || state_d == DONE) begin
            phase_d = '0;
        end else if (state_d == COOK && state_q != COOK) begin
            phase_d = '0;
            level_d = level_sat;
        end else if (state_q == COOK) begin
            if (phase_q == PHASE_LAST) begin
                phase_d = '0;
                level_d = level_sat;
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end

        done_pulse_d = (state_d == DONE) && (state_q != DONE);
        on_cnt       = CW'((int'(level_q) + 1) * STEP);
    end

    // NOTE: state is updated with non-blocking assignments, so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            phase_q      <= '0;
            level_q      <= '0;
            done_pulse_q <= 1'b0;
            start_q      <= 1'b1;
            stop_q       <= 1'b1;
            clear_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            level_q      <= level_d;
            done_pulse_q <= done_pulse_d;
            start_q      <= startn;
            stop_q       <= stopn;
            clear_q      <= clearn;
        end
    end

    // The door gates mag_on directly, so opening it cuts power in the same cycle.
    assign mag_on     = (state_q == COOK) & door_closed & ({1'b0, phase_q} < on_cnt);
    assign state_o    = state_q;
    assign level_o    = level_q;
    assign done_pulse = done_pulse_q;

endmodule
